// File: rtl/hi_lo_controller.sv
// HI/LO register unit: multi-cycle multiply (with accumulate) and restoring divide,
// plus MTHI/MTLO writes and combinational MFHI/MFLO reads.
module hi_lo_controller #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        OpValid,
  input  logic [3:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] ReadData,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        DivByZero
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MSUB  = 4'd10
  } op_t;

  state_t      state_q, state_d;
  op_t         mop_q, mop_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] rem_q, rem_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dbz_q, dbz_d;

  op_t         op_in;
  logic        is_nop;
  logic        div_signed;
  logic [63:0] prod_s, prod_u, mul_res;
  logic [32:0] shifted, diff;

  assign op_in  = op_t'(Op);
  assign is_nop = (Op == 4'd0) || (Op > 4'd10);

  assign Busy      = (state_q != S_IDLE);
  assign Stall     = OpValid && Busy && !is_nop;
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign DivByZero = dbz_q;

  always_comb begin
    ReadData = '0;
    if (op_in == OP_MFHI)      ReadData = hi_q;
    else if (op_in == OP_MFLO) ReadData = lo_q;
  end

  always_comb begin
    prod_s = $signed({{32{op_a_q[31]}}, op_a_q}) * $signed({{32{op_b_q[31]}}, op_b_q});
    prod_u = {32'd0, op_a_q} * {32'd0, op_b_q};
    case (mop_q)
      OP_MULTU: mul_res = prod_u;
      OP_MADD:  mul_res = acc_q + prod_s;
      OP_MSUB:  mul_res = acc_q - prod_s;
      default:  mul_res = prod_s;
    endcase
  end

  // During DIV, op_a_q doubles as the dividend/quotient shift register and
  // op_b_q holds the divisor magnitude.
  assign shifted = {rem_q, op_a_q[31]};
  assign diff    = shifted - {1'b0, op_b_q};

  always_comb begin
    state_d    = state_q;
    mop_d      = mop_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dbz_d      = 1'b0;
    div_signed = (op_in == OP_DIV);
    case (state_q)
      S_IDLE: begin
        if (OpValid) begin
          case (op_in)
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
              op_a_d  = A;
              op_b_d  = B;
              acc_d   = {hi_q, lo_q};
              mop_d   = op_in;
              cnt_d   = 6'(MUL_LAT - 1);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (B == '0) begin
                dbz_d = 1'b1;
              end else begin
                neg_quo_d = div_signed && (A[31] ^ B[31]);
                neg_rem_d = div_signed && A[31];
                op_a_d    = (div_signed && A[31]) ? -A : A;
                op_b_d    = (div_signed && B[31]) ? -B : B;
                rem_d     = '0;
                cnt_d     = '0;
                state_d   = S_DIV;
              end
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = mul_res;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DIV: begin
        if (cnt_q == 6'd32) begin
          hi_d    = neg_rem_q ? -rem_q : rem_q;
          lo_d    = neg_quo_q ? -op_a_q : op_a_q;
          state_d = S_IDLE;
        end else begin
          rem_d  = diff[32] ? shifted[31:0] : diff[31:0];
          op_a_d = {op_a_q[30:0], ~diff[32]};
          cnt_d  = cnt_q + 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      mop_q     <= OP_NOP;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mop_q     <= mop_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
    end
  end

endmodule

// File: tb/tb_hi_lo_controller.sv
// Bench for hi_lo_controller: directed cases plus randomized ops checked against
// an arithmetic reference model of the HI/LO registers.
module tb_hi_lo_controller;
  localparam int unsigned LAT = 4;

  logic        Clk = 1'b0;
  logic        Reset, OpValid;
  logic [3:0]  Op;
  logic [31:0] A, B, ReadData, Hi, Lo;
  logic        Busy, Stall, DivByZero;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi, m_lo;

  always #5 Clk = ~Clk;

  hi_lo_controller #(.MUL_LAT(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .OpValid(OpValid), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Stall(Stall), .ReadData(ReadData), .Hi(Hi), .Lo(Lo),
    .DivByZero(DivByZero)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: updates m_hi/m_lo, returns expected busy length and div-by-zero.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic dbz);
    longint      sp;
    logic [63:0] up, hl;
    int          sq, sr;
    sp  = longint'(int'(a)) * longint'(int'(b));
    up  = 64'(a) * 64'(b);
    hl  = {m_hi, m_lo};
    lat = 0;
    dbz = 1'b0;
    case (op)
      4'd1:  begin hl = sp;      lat = LAT; end
      4'd2:  begin hl = up;      lat = LAT; end
      4'd9:  begin hl = hl + sp; lat = LAT; end
      4'd10: begin hl = hl - sp; lat = LAT; end
      4'd3: begin
        if (b == 0) dbz = 1'b1;
        else begin
          lat = 33;
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) hl = {32'd0, 32'h8000_0000};
          else begin
            sq = int'(a) / int'(b);
            sr = int'(a) % int'(b);
            hl = {32'(sr), 32'(sq)};
          end
        end
      end
      4'd4: begin
        if (b == 0) dbz = 1'b1;
        else begin
          lat = 33;
          hl  = {a % b, a / b};
        end
      end
      4'd5: hl[63:32] = a;
      4'd6: hl[31:0]  = a;
      default: ;
    endcase
    {m_hi, m_lo} = hl;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    int          lat, cycles;
    logic        dbz;
    logic [31:0] old_hi, old_lo, exp_rd;
    OpValid = 1'b1; Op = op; A = a; B = b;
    exp_rd  = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
    #1;
    check({tag, " readdata"}, ReadData, exp_rd);
    check({tag, " stall_idle"}, Stall, 1'b0);
    old_hi = m_hi;
    old_lo = m_lo;
    model(op, a, b, lat, dbz);
    tick();
    OpValid = 1'b0; Op = 4'd0;
    check({tag, " busy_after_accept"}, Busy, lat != 0);
    check({tag, " divbyzero"}, DivByZero, dbz);
    if (lat != 0) begin
      cycles = 0;
      while (Busy && cycles < 100) begin
        check({tag, " hilo_held_busy"}, {Hi, Lo}, {old_hi, old_lo});
        tick();
        cycles++;
      end
      check({tag, " busy_cycles"}, cycles, lat);
    end else if (dbz) begin
      tick();
      check({tag, " divbyzero_fall"}, DivByZero, 1'b0);
    end
    check({tag, " hi"}, Hi, m_hi);
    check({tag, " lo"}, Lo, m_lo);
  endtask

  initial begin
    int          lat, cycles;
    logic        dbz;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    Reset = 1'b1; OpValid = 1'b0; Op = '0; A = '0; B = '0;
    tick(); tick();
    Reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("reset_hi", Hi, 32'd0);
    check("reset_lo", Lo, 32'd0);
    check("reset_busy", Busy, 1'b0);
    check("reset_dbz", DivByZero, 1'b0);

    issue(4'd5, 32'hFFFF_FFFF, 32'd0, "mthi");
    issue(4'd6, 32'h0000_0001, 32'd0, "mtlo");
    check("mthi_mtlo_const", {Hi, Lo}, 64'hFFFF_FFFF_0000_0001);

    issue(4'd1, 32'hFFFF_FFFF, 32'd2, "mult");
    check("mult_const", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(4'd2, 32'hFFFF_FFFF, 32'd2, "multu");
    check("multu_const", {Hi, Lo}, 64'h0000_0001_FFFF_FFFE);

    // DIV -7/2 with MFLO held during Busy
    OpValid = 1'b1; Op = 4'd3; A = 32'hFFFF_FFF9; B = 32'd2;
    model(4'd3, A, B, lat, dbz);
    tick();
    Op = 4'd8;
    cycles = 0;
    while (Busy && cycles < 100) begin
      check("div_mflo_stall", Stall, 1'b1);
      tick();
      cycles++;
    end
    check("div_busy_cycles", cycles, 33);
    check("div_mflo_stall_fall", Stall, 1'b0);
    check("div_mflo_readdata", ReadData, 32'hFFFF_FFFD);
    check("div_const", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    tick();
    OpValid = 1'b0; Op = 4'd0;
    check("mflo_no_change", {Hi, Lo}, {m_hi, m_lo});

    issue(4'd5, 32'h11, 32'd0, "mthi11");
    issue(4'd6, 32'h22, 32'd0, "mtlo22");
    issue(4'd4, 32'd100, 32'd0, "divu_zero");
    check("divu_zero_const", {Hi, Lo}, {32'h11, 32'h22});

    issue(4'd5, 32'd0, 32'd0, "mthi0");
    issue(4'd6, 32'd10, 32'd0, "mtlo10");
    issue(4'd10, 32'd3, 32'd4, "msub");
    check("msub_const", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFE);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_const", {Hi, Lo}, {32'd0, 32'h8000_0000});

    // MTHI held during MULT Busy must be ignored, not queued
    OpValid = 1'b1; Op = 4'd1; A = 32'd3; B = 32'd5;
    model(4'd1, A, B, lat, dbz);
    tick();
    Op = 4'd5; A = 32'hDEAD_BEEF;
    cycles = 0;
    while (Busy && cycles < 100) begin
      check("mul_mthi_stall", Stall, 1'b1);
      tick();
      cycles++;
    end
    OpValid = 1'b0; Op = 4'd0;
    check("mul_ignore_cycles", cycles, LAT);
    check("mul_ignore_hilo", {Hi, Lo}, 64'd15);

    // Reset in the middle of a DIVU
    issue(4'd5, 32'h5, 32'd0, "mthi5");
    OpValid = 1'b1; Op = 4'd4; A = 32'd100; B = 32'd7;
    tick();
    OpValid = 1'b0; Op = 4'd0;
    repeat (9) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("abort_hilo", {Hi, Lo}, 64'd0);
    check("abort_busy", Busy, 1'b0);
    repeat (40) tick();
    check("abort_no_late_write", {Hi, Lo}, 64'd0);
    check("abort_busy_late", Busy, 1'b0);

    issue(4'd5, 32'h77, 32'd0, "mthi77");
    Reset = 1'b1; OpValid = 1'b1; Op = 4'd6; A = 32'h123;
    tick();
    Reset = 1'b0; OpValid = 1'b0; Op = 4'd0;
    m_hi = '0; m_lo = '0;
    check("reset_dominates", {Hi, Lo}, 64'd0);

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 9));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      issue(rop, ra, rb, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hi_lo_controller.md
HI_LO_CONTROLLER -- requirements
Module: hi_lo_controller

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, multiply latency in cycles from acceptance to HI/LO update; legal range 1..15.
REQ-002 SHALL have port Clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port OpValid  in  1  request valid.
REQ-005 SHALL have port Op  in  4  opcode: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MSUB; 11-15 treated as NOP.
REQ-006 SHALL have port A  in  32  operand A (dividend, multiplicand, MTHI/MTLO data).
REQ-007 SHALL have port B  in  32  operand B (divisor, multiplier).
REQ-008 SHALL have port Busy  out  1  multi-cycle operation in progress.
REQ-009 SHALL have port Stall  out  1  combinational; OpValid && Busy && Op not NOP.
REQ-010 SHALL have port ReadData  out  32  combinational; Hi when Op=MFHI, Lo when Op=MFLO, else 0.
REQ-011 SHALL have ports Hi, Lo  out  32 each  current HI/LO register contents.
REQ-012 SHALL have port DivByZero  out  1  one-cycle pulse on DIV/DIVU with B=0.

Function
REQ-013 SHALL implement state machine IDLE, MUL, DIV; request accepted only in IDLE when OpValid=1 at a rising edge.
REQ-014 Requests while Busy=1 SHALL be ignored (not queued); requester holds Op/A/B while Stall=1.
REQ-015 MTHI/MTLO accepted at edge k SHALL write A into Hi/Lo at edge k; no Busy.
REQ-016 MFHI/MFLO SHALL not change state; ReadData valid same cycle, stalled while Busy.
REQ-017 MULT/MULTU/MADD/MSUB accepted at edge k SHALL latch A, B (and for MADD/MSUB current {Hi,Lo}), enter MUL, Busy=1 after edge k.
REQ-018 MUL result SHALL write {Hi,Lo} at edge k+MUL_LAT, return to IDLE; Busy=0 after that edge.
REQ-019 MULT/MADD/MSUB SHALL treat A, B signed; MULTU unsigned; MADD {Hi,Lo}+=A*B, MSUB {Hi,Lo}-=A*B, 64-bit wrap-around, no overflow flag.
REQ-020 DIV/DIVU with B!=0 accepted at edge k SHALL enter DIV, iterate one restoring-division bit per cycle for 32 cycles, apply sign fixup, write at edge k+33, Busy=0 after.
REQ-021 Division SHALL write Lo=quotient, Hi=remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give Lo=0x80000000, Hi=0.
REQ-023 DIV/DIVU with B=0 SHALL leave Hi/Lo unchanged, pulse DivByZero for the cycle after edge k, stay IDLE, Busy=0.
REQ-024 Hi/Lo SHALL change only at edges specified in REQ-015, 018, 020, and Reset.
REQ-025 New request SHALL be acceptable at the same edge Busy falls is NOT allowed; first acceptable edge is the one after Busy=0 is observed.

Reset
REQ-026 Reset=1 at an edge SHALL force IDLE, Hi=0, Lo=0, Busy=0, DivByZero=0, clear iteration counter and latched operands.
REQ-027 Reset SHALL abort an in-progress MUL/DIV with no partial result written; Reset dominates a simultaneous OpValid.
REQ-028 Outputs before first Reset edge are undefined.

Verification
REQ-029 Reset, then MTHI A=0xFFFFFFFF, MTLO A=0x00000001 -> Hi=0xFFFFFFFF, Lo=0x00000001 one edge each, Busy never 1.
REQ-030 MULT A=0xFFFFFFFF B=0x00000002 -> Busy 4 cycles, Hi=0xFFFFFFFF, Lo=0xFFFFFFFE; MULTU same operands -> Hi=0x00000001, Lo=0xFFFFFFFE.
REQ-031 DIV A=0xFFFFFFF9 (-7) B=2 -> Busy 33 cycles, Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; MFLO issued during Busy -> Stall=1 until Busy falls, then ReadData=0xFFFFFFFD.
REQ-032 DIVU A=100 B=0 with Hi=0x11, Lo=0x22 -> DivByZero one cycle, Hi/Lo unchanged, Busy=0.
REQ-033 Start DIVU A=100 B=7, assert Reset at cycle 10 -> Hi=Lo=0, Busy=0 next cycle, no result written later.
REQ-034 Hi=0, Lo=10, MSUB A=3 B=4 -> {Hi,Lo}=0xFFFFFFFF_FFFFFFFE after MUL_LAT cycles.
